cascade_param_reader: RTL and testbench
=======================================

# cascade_param_reader

Parameter sequencer that drives the per-window weak-classifier stream into the stage accumulator. Walks a cascade description stored in a 32-bit parameter RAM, emits per-classifier threshold and left/right alpha words with their type tags, issues the stage-clear strobe, and collects each classifier's accumulated result. At each stage end it compares the float stage sum against the stage threshold and produces the pass/reject verdict for the window. Sits between the cascade parameter RAM and the stage accumulator, under the window scheduler.

## Interface
- ADDR_W, 12, parameter RAM word-address width
- MEM_LAT, 2, parameter RAM read latency in cycles (≥1)
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  one-cycle pulse: evaluate the cascade for the current window
- busy_o  out  1  high from the cycle after an accepted start_i until done_o
- mem_rd_o  out  1  read strobe, one cycle per word
- mem_addr_o  out  ADDR_W  read address, valid with mem_rd_o
- mem_data_i  in  32  read data, valid exactly MEM_LAT cycles after mem_rd_o
- new_stage_o  out  1  one-cycle pulse clearing the downstream stage accumulator
- thresholds_o  out  32  float word: classifier threshold or alpha
- thresholds_type_o  out  2  `THRESHOLD, `LEFT_VAL or `RIGHT_VAL (defs.vh)
- thresholds_val_o  out  1  one-cycle qualifier for thresholds_o/type
- stage_sum_i  in  32  running float stage sum from the accumulator
- stage_sum_val_i  in  1  stage_sum_i valid: one per classifier
- done_o  out  1  one-cycle pulse: verdict ready
- pass_o  out  1  verdict, held from done_o until next accepted start_i
- fail_stage_o  out  8  index of rejecting stage, held like pass_o; 0 on pass

## Operation
- RAM layout, linear from address 0: word 0 = S (stage count, unsigned int, low 8 bits used). Per stage: N (classifier count, unsigned int, low 16 bits used), then stage threshold (float). Per classifier: threshold, left alpha, right alpha (floats).
- Address pointer resets to 0 on each accepted start_i and increments by 1 per read; it wraps modulo 2^ADDR_W without error.
- Each read: mem_rd_o high one cycle, then a wait counter of MEM_LAT cycles. mem_data_i is captured on the MEM_LAT-th cycle. Only one read is outstanding.
- States:
  - IDLE: start_i → RD_S.
  - RD_S: if S=0 → FINISH(pass) else RD_N.
  - RD_N → RD_STHR → NEWSTG.
  - NEWSTG: new_stage_o pulse, stage-sum register cleared to +0.0; N=0 → CHECK else RD_T.
  - RD_T → RD_L → RD_R: each captured word is re-emitted on thresholds_o with thresholds_val_o and its type (THRESHOLD, LEFT_VAL, RIGHT_VAL).
  - After RD_R emits → WAIT_SUM.
  - WAIT_SUM: on stage_sum_val_i capture stage_sum_i and decrement the classifier counter; count>0 → RD_T, else → CHECK.
  - CHECK: pass stage if captured sum ≥ stage threshold. Pass and more stages → RD_N; pass on last stage → FINISH(pass=1, fail_stage=0); fail → FINISH(pass=0, fail_stage=current stage index, 0-based).
  - FINISH: done_o pulse → IDLE.
- Float compare is IEEE-754 single ordering, no NaN/Inf handling. +0.0 equals -0.0. Same signs: compare magnitudes, reversed if negative. Mixed signs: the positive operand is greater.
- start_i while busy: ignored. stage_sum_val_i outside WAIT_SUM: ignored.
- Reset (any time, including mid-cascade): FSM → IDLE, counters/pointer 0, all outputs 0.

## Timing
- Reset values: busy_o 0, mem_rd_o 0, mem_addr_o 0, new_stage_o 0, thresholds_o 0, thresholds_type_o 0, thresholds_val_o 0, done_o 0, pass_o 0, fail_stage_o 0.
- All outputs registered.
- Read issued cycle t → data captured at t+MEM_LAT → thresholds_val_o high at t+MEM_LAT+1. Next read issued the same cycle the previous word is emitted.
- Per-classifier word spacing: MEM_LAT+1 cycles; the three words of one classifier are never interleaved with another's.
- new_stage_o precedes the stage's first thresholds_val_o by ≥1 cycle.
- CHECK takes 1 cycle. done_o follows the final CHECK by 1 cycle. pass_o/fail_stage_o are valid in the cycle done_o is high.

## Test plan
- S=0 in RAM, start_i → done_o with pass_o=1, fail_stage_o=0; no new_stage_o and no thresholds_val_o.
- S=1, N=1, stage thr 0.5, words 0.1/0.3/0.7, MEM_LAT=2; stage_sum_i=0.7 after the third word → three val pulses 3 cycles apart with correct types, one new_stage_o, pass_o=1.
- S=2, stage thresholds 1.0 and 2.0, sums 1.5 then 1.9 → new_stage_o twice, pass_o=0, fail_stage_o=1.
- Compare edges: sum -0.0 vs thr +0.0 → pass. Sum -1.0 vs thr -2.0 → pass. Sum -2.0 vs thr -1.0 → fail.
- Stage with N=0, thr -0.5 → passes on +0.0 without waiting for stage_sum_val_i. Spurious stage_sum_val_i during reads → ignored.
- rst_i asserted mid-WAIT_SUM, then a fresh start_i → all outputs 0 during reset; second run reads from address 0 and completes normally. start_i while busy → no effect.

Source files
------------

// File: rtl/cascade_param_reader.sv
// Cascade parameter sequencer: walks the parameter RAM for one window, streams
// classifier words to the stage accumulator and resolves the pass/reject verdict.
module cascade_param_reader #(
  parameter int ADDR_W  = 12,
  parameter int MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_data_i,
  output logic              new_stage_o,
  output logic [31:0]       thresholds_o,
  output logic [1:0]        thresholds_type_o,
  output logic              thresholds_val_o,
  input  logic [31:0]       stage_sum_i,
  input  logic              stage_sum_val_i,
  output logic              done_o,
  output logic              pass_o,
  output logic [7:0]        fail_stage_o
);

  localparam logic [1:0] THRESHOLD = 2'd0;
  localparam logic [1:0] LEFT_VAL  = 2'd1;
  localparam logic [1:0] RIGHT_VAL = 2'd2;
  localparam int         LAT_W     = $clog2(MEM_LAT + 1);

  typedef enum logic [3:0] {
    IDLE, RD_S, RD_N, RD_STHR, NEWSTG, RD_T, RD_L, RD_R, WAIT_SUM, CHECK, FINISH
  } state_t;

  state_t           state;
  logic [LAT_W-1:0] wait_cnt;
  logic [7:0]       stages_left;
  logic [7:0]       stage_idx;
  logic [15:0]      cls_left;
  logic [31:0]      stage_thr;
  logic [31:0]      stage_sum;
  logic             data_rdy;
  logic             sum_ge_thr;

  // IEEE-754 single ordering without NaN/Inf; both zeros compare equal.
  function automatic logic f_ge(input logic [31:0] a, input logic [31:0] b);
    logic r;
    if (a[30:0] == 31'd0 && b[30:0] == 31'd0) r = 1'b1;
    else if (a[31] != b[31])                  r = b[31];
    else if (a[31])                           r = (a[30:0] <= b[30:0]);
    else                                      r = (a[30:0] >= b[30:0]);
    return r;
  endfunction

  // The read strobe marks the issue cycle, so the countdown starts one cycle later
  // and reaches zero exactly MEM_LAT cycles after the strobe.
  assign data_rdy   = !mem_rd_o && (wait_cnt == '0);
  assign sum_ge_thr = f_ge(stage_sum, stage_thr);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state             <= IDLE;
      wait_cnt          <= '0;
      stages_left       <= '0;
      stage_idx         <= '0;
      cls_left          <= '0;
      stage_thr         <= '0;
      stage_sum         <= '0;
      busy_o            <= 1'b0;
      mem_rd_o          <= 1'b0;
      mem_addr_o        <= '0;
      new_stage_o       <= 1'b0;
      thresholds_o      <= '0;
      thresholds_type_o <= '0;
      thresholds_val_o  <= 1'b0;
      done_o            <= 1'b0;
      pass_o            <= 1'b0;
      fail_stage_o      <= '0;
    end else begin
      // NOTE: pulse outputs default low here; later non-blocking assignments in the
      // case below override them, so the last assignment in program order wins.
      mem_rd_o         <= 1'b0;
      new_stage_o      <= 1'b0;
      thresholds_val_o <= 1'b0;
      done_o           <= 1'b0;

      if (mem_rd_o) begin
        mem_addr_o <= mem_addr_o + ADDR_W'(1);
        wait_cnt   <= LAT_W'(MEM_LAT - 1);
      end else if (wait_cnt != '0) begin
        wait_cnt <= wait_cnt - LAT_W'(1);
      end

      case (state)
        IDLE: if (start_i) begin
          busy_o       <= 1'b1;
          pass_o       <= 1'b0;
          fail_stage_o <= '0;
          stage_idx    <= '0;
          mem_addr_o   <= '0;
          mem_rd_o     <= 1'b1;
          state        <= RD_S;
        end
        RD_S: if (data_rdy) begin
          stages_left <= mem_data_i[7:0];
          if (mem_data_i[7:0] == 8'd0) begin
            pass_o <= 1'b1;
            done_o <= 1'b1;
            state  <= FINISH;
          end else begin
            mem_rd_o <= 1'b1;
            state    <= RD_N;
          end
        end
        RD_N: if (data_rdy) begin
          cls_left <= mem_data_i[15:0];
          mem_rd_o <= 1'b1;
          state    <= RD_STHR;
        end
        RD_STHR: if (data_rdy) begin
          stage_thr <= mem_data_i;
          state     <= NEWSTG;
        end
        NEWSTG: begin
          new_stage_o <= 1'b1;
          stage_sum   <= '0;
          if (cls_left == 16'd0) begin
            state <= CHECK;
          end else begin
            mem_rd_o <= 1'b1;
            state    <= RD_T;
          end
        end
        RD_T: if (data_rdy) begin
          thresholds_o      <= mem_data_i;
          thresholds_type_o <= THRESHOLD;
          thresholds_val_o  <= 1'b1;
          mem_rd_o          <= 1'b1;
          state             <= RD_L;
        end
        RD_L: if (data_rdy) begin
          thresholds_o      <= mem_data_i;
          thresholds_type_o <= LEFT_VAL;
          thresholds_val_o  <= 1'b1;
          mem_rd_o          <= 1'b1;
          state             <= RD_R;
        end
        RD_R: if (data_rdy) begin
          thresholds_o      <= mem_data_i;
          thresholds_type_o <= RIGHT_VAL;
          thresholds_val_o  <= 1'b1;
          state             <= WAIT_SUM;
        end
        WAIT_SUM: if (stage_sum_val_i) begin
          stage_sum <= stage_sum_i;
          cls_left  <= cls_left - 16'd1;
          if (cls_left == 16'd1) begin
            state <= CHECK;
          end else begin
            mem_rd_o <= 1'b1;
            state    <= RD_T;
          end
        end
        CHECK: begin
          if (!sum_ge_thr) begin
            pass_o       <= 1'b0;
            fail_stage_o <= stage_idx;
            done_o       <= 1'b1;
            state        <= FINISH;
          end else if (stages_left == 8'd1) begin
            pass_o       <= 1'b1;
            fail_stage_o <= '0;
            done_o       <= 1'b1;
            state        <= FINISH;
          end else begin
            stages_left <= stages_left - 8'd1;
            stage_idx   <= stage_idx + 8'd1;
            mem_rd_o    <= 1'b1;
            state       <= RD_N;
          end
        end
        FINISH: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cascade_param_reader.sv
// Bench for cascade_param_reader: RAM and accumulator models around the DUT, with a
// cascade-walking reference model and a per-cycle compare process.
module tb_cascade_param_reader;

  localparam int         ADDR_W    = 12;
  localparam int         MEM_LAT   = 2;
  localparam int         MEM_WORDS = 1 << ADDR_W;
  localparam logic [1:0] THRESHOLD = 2'd0;
  localparam logic [1:0] LEFT_VAL  = 2'd1;
  localparam logic [1:0] RIGHT_VAL = 2'd2;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic              busy_o;
  logic              mem_rd_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_data_i;
  logic              new_stage_o;
  logic [31:0]       thresholds_o;
  logic [1:0]        thresholds_type_o;
  logic              thresholds_val_o;
  logic [31:0]       stage_sum_i = 32'h0;
  logic              stage_sum_val_i = 1'b0;
  logic              done_o;
  logic              pass_o;
  logic [7:0]        fail_stage_o;

  cascade_param_reader #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o),
    .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .new_stage_o(new_stage_o), .thresholds_o(thresholds_o),
    .thresholds_type_o(thresholds_type_o), .thresholds_val_o(thresholds_val_o),
    .stage_sum_i(stage_sum_i), .stage_sum_val_i(stage_sum_val_i),
    .done_o(done_o), .pass_o(pass_o), .fail_stage_o(fail_stage_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
  endtask

  // Parameter RAM: data appears exactly MEM_LAT cycles after the strobe, garbage otherwise.
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] pipe [MEM_LAT];
  assign mem_data_i = pipe[MEM_LAT-1];
  always @(posedge clk_i) begin
    pipe[0] <= mem_rd_o ? mem[mem_addr_o] : $urandom;
    for (int k = 1; k < MEM_LAT; k++) pipe[k] <= pipe[k-1];
  end

  // Scenario description and expectations, written by the stimulus only.
  logic [31:0] sums_plan [$];
  logic [33:0] exp_words [$];
  int          exp_ns;
  bit          exp_pass;
  int          exp_fail;
  int          run_id = 0;
  bit          armed = 1'b0;
  bit          spurious = 1'b0;
  bit          no_respond = 1'b0;
  int          wp;

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    e = int'(b[30:23]);
    m = real'(b[22:0]) / 8388608.0;
    if (e == 0) e = -126;
    else begin m = m + 1.0; e = e - 127; end
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] rnd_float();
    logic [31:0] f;
    if ($urandom_range(0, 9) == 0) f = {1'($urandom_range(0, 1)), 31'h0};
    else f = {1'($urandom_range(0, 1)), 8'($urandom_range(124, 130)), 23'($urandom)};
    return f;
  endfunction

  task automatic put(input logic [31:0] w);
    mem[wp % MEM_WORDS] = w;
    wp++;
  endtask

  task automatic begin_cascade(input int s);
    wp = 0;
    sums_plan.delete();
    put(32'(s));
  endtask

  task automatic add_stage(input int n, input logic [31:0] thr);
    put(32'(n));
    put(thr);
  endtask

  task automatic add_cls(input logic [31:0] t, input logic [31:0] l, input logic [31:0] r,
                         input logic [31:0] sum);
    put(t); put(l); put(r);
    sums_plan.push_back(sum);
  endtask

  // Reference: walk the cascade as stored, stopping at the first rejecting stage.
  task automatic model();
    int          a, s, n, si;
    logic [31:0] thr, last;
    logic [1:0]  tags [3];
    tags[0] = THRESHOLD; tags[1] = LEFT_VAL; tags[2] = RIGHT_VAL;
    exp_words.delete();
    exp_ns = 0; exp_pass = 1'b1; exp_fail = 0; si = 0;
    s = int'(mem[0][7:0]);
    a = 1;
    for (int st = 0; st < s; st++) begin
      n   = int'(mem[a % MEM_WORDS][15:0]);
      thr = mem[(a + 1) % MEM_WORDS];
      a  += 2;
      exp_ns++;
      last = 32'h0;
      for (int c = 0; c < n; c++) begin
        for (int k = 0; k < 3; k++) exp_words.push_back({tags[k], mem[(a + k) % MEM_WORDS]});
        a += 3;
        last = (si < sums_plan.size()) ? sums_plan[si] : 32'h0;
        si++;
      end
      if (!(f2r(last) >= f2r(thr))) begin
        exp_pass = 1'b0;
        exp_fail = st;
        break;
      end
    end
  endtask

  // Stage accumulator stand-in: answers each right-alpha word, optionally with noise.
  int resp_run = 0;
  int ridx = 0;
  bit pending = 1'b0;
  int delay = 0;
  int right_seen = 0;
  always @(negedge clk_i) begin
    if (run_id != resp_run) begin resp_run = run_id; ridx = 0; pending = 1'b0; end
    stage_sum_val_i = 1'b0;
    if (rst_i) pending = 1'b0;
    else begin
      if (thresholds_val_o && thresholds_type_o == RIGHT_VAL) begin
        right_seen++;
        if (!no_respond) begin pending = 1'b1; delay = $urandom_range(0, 3); end
      end
      if (pending) begin
        if (delay == 0) begin
          stage_sum_val_i = 1'b1;
          stage_sum_i = (ridx < sums_plan.size()) ? sums_plan[ridx] : 32'h0;
          ridx++;
          pending = 1'b0;
        end else delay--;
      end else if (spurious && $urandom_range(0, 3) == 0) begin
        stage_sum_val_i = 1'b1;
        stage_sum_i = $urandom;
      end
    end
  end

  // Compare process: every cycle, against the reference expectations.
  int cyc = 0;
  int cur_run = 0;
  int eidx = 0;
  int exp_addr = 0;
  int ns_seen = 0;
  int last_val = 0;
  int done_run = 0;
  always @(negedge clk_i) begin
    cyc++;
    if (run_id != cur_run) begin
      cur_run = run_id; eidx = 0; exp_addr = 0; ns_seen = 0;
    end
    if (rst_i) begin
      check("reset_outputs", {busy_o, mem_rd_o, mem_addr_o, new_stage_o, thresholds_o,
                              thresholds_type_o, thresholds_val_o, done_o, pass_o,
                              fail_stage_o}, 64'h0);
    end else if (armed) begin
      if (mem_rd_o) begin
        check("rd_addr", mem_addr_o, exp_addr);
        exp_addr = (exp_addr + 1) % MEM_WORDS;
      end
      if (new_stage_o) begin
        ns_seen++;
        check("new_stage_vs_val", thresholds_val_o, 1'b0);
      end
      if (thresholds_val_o) begin
        if (eidx >= exp_words.size()) check("unexpected_val", thresholds_val_o, 1'b0);
        else begin
          check("word", {thresholds_type_o, thresholds_o}, exp_words[eidx]);
          check("next_read_with_emit", mem_rd_o, exp_words[eidx][33:32] != RIGHT_VAL);
          if (exp_words[eidx][33:32] != THRESHOLD)
            check("word_spacing", cyc - last_val, MEM_LAT + 1);
          check("busy_during_run", busy_o, 1'b1);
          eidx++;
        end
        last_val = cyc;
      end
      if (done_o) begin
        check("verdict", {pass_o, fail_stage_o}, {exp_pass, 8'(exp_fail)});
        check("words_consumed", eidx, exp_words.size());
        check("new_stage_count", ns_seen, exp_ns);
        done_run = run_id;
      end
    end
  end

  task automatic run_case(input string nm, input bit has_lit, input bit lit_pass,
                          input int lit_fail, input bit spur, input bit poke);
    model();
    if (has_lit) begin
      check({nm, "_model_pass"}, exp_pass, lit_pass);
      check({nm, "_model_fail"}, exp_fail, lit_fail);
    end
    spurious = spur;
    run_id++;
    armed = 1'b1;
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    check({nm, "_busy_after_start"}, busy_o, 1'b1);
    if (poke) begin
      repeat ($urandom_range(2, 6)) @(negedge clk_i);
      start_i = 1'b1;
      @(negedge clk_i); start_i = 1'b0;
    end
    for (int i = 0; i < 4000 && done_run != run_id; i++) @(negedge clk_i);
    check({nm, "_done_seen"}, done_run, run_id);
    @(negedge clk_i);
    check({nm, "_idle_after_done"}, {busy_o, done_o}, 2'b00);
    check({nm, "_held_verdict"}, {pass_o, fail_stage_o}, {exp_pass, 8'(exp_fail)});
    if (has_lit) check({nm, "_literal_verdict"}, {pass_o, fail_stage_o}, {lit_pass, 8'(lit_fail)});
    spurious = 1'b0;
    repeat (3) @(negedge clk_i);
  endtask

  task automatic build_two_stage();
    begin_cascade(2);
    add_stage(1, 32'h3F80_0000);                                       // thr 1.0
    add_cls(32'h3DCC_CCCD, 32'h3E99_999A, 32'h3F33_3333, 32'h3FC0_0000); // sum 1.5
    add_stage(1, 32'h4000_0000);                                       // thr 2.0
    add_cls(32'h3F00_0000, 32'hBF00_0000, 32'h3F80_0000, 32'h3FF3_3333); // sum 1.9
  endtask

  initial begin
    int base;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    begin_cascade(0);
    run_case("s_zero", 1'b1, 1'b1, 0, 1'b0, 1'b0);

    begin_cascade(1);
    add_stage(1, 32'h3F00_0000);
    add_cls(32'h3DCC_CCCD, 32'h3E99_999A, 32'h3F33_3333, 32'h3F33_3333);
    model();
    check("single_model_words", exp_words.size(), 3);
    run_case("single", 1'b1, 1'b1, 0, 1'b0, 1'b0);

    build_two_stage();
    model();
    check("two_stage_model_ns", exp_ns, 2);
    run_case("two_stage", 1'b1, 1'b0, 1, 1'b0, 1'b0);

    begin_cascade(3);
    add_stage(1, 32'h0000_0000);
    add_cls(32'h3F80_0000, 32'h4000_0000, 32'hC000_0000, 32'h8000_0000); // -0.0 vs +0.0
    add_stage(1, 32'hC000_0000);
    add_cls(32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000, 32'hBF80_0000); // -1.0 vs -2.0
    add_stage(1, 32'hBF80_0000);
    add_cls(32'h3E80_0000, 32'h3E80_0000, 32'h3E80_0000, 32'hC000_0000); // -2.0 vs -1.0
    run_case("float_edges", 1'b1, 1'b0, 2, 1'b0, 1'b0);

    begin_cascade(2);
    add_stage(0, 32'hBF00_0000);
    add_stage(2, 32'h0000_0000);
    add_cls(32'h3F00_0000, 32'hBF00_0000, 32'h3F80_0000, 32'hBF80_0000);
    add_cls(32'h3E00_0000, 32'h3D00_0000, 32'h3C00_0000, 32'h3F00_0000);
    run_case("empty_stage_spurious", 1'b1, 1'b1, 0, 1'b1, 1'b0);

    // Abort in WAIT_SUM, then a fresh run must start again from address 0.
    build_two_stage();
    model();
    no_respond = 1'b1;
    base = right_seen;
    run_id++;
    armed = 1'b1;
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    for (int i = 0; i < 200 && right_seen == base; i++) @(negedge clk_i);
    check("abort_reached_wait_sum", right_seen > base, 1'b1);
    repeat (2) @(negedge clk_i);
    @(posedge clk_i); #1 armed = 1'b0; rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    no_respond = 1'b0;
    run_case("after_reset", 1'b1, 1'b0, 1, 1'b0, 1'b1);

    for (int r = 0; r < 30; r++) begin
      int s;
      s = $urandom_range(1, 4);
      begin_cascade(s);
      for (int st = 0; st < s; st++) begin
        int          n;
        logic [31:0] thr;
        n   = $urandom_range(0, 3);
        thr = rnd_float();
        add_stage(n, thr);
        for (int c = 0; c < n; c++)
          add_cls(rnd_float(), rnd_float(), rnd_float(),
                  ($urandom_range(0, 3) == 0) ? thr : rnd_float());
      end
      run_case("random", 1'b0, 1'b0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
